// File: rtl/fx_bus_pkg.sv
// Shared definitions for the fx register bus master: opcodes, FSM states and bus widths.
package fx_bus_pkg;

    localparam int FX_AW = 22;
    localparam int FX_DW = 8;

    localparam logic [7:0] OP_WR = 8'h01;
    localparam logic [7:0] OP_RD = 8'h02;

    typedef enum logic [3:0] {
        IDLE,
        ADR2,
        ADR1,
        ADR0,
        LEN,
        WDAT,
        RISS,
        RWAIT,
        RSND
    } fx_state_e;

endpackage

// File: rtl/fx_bus_master_if.sv
// Host byte streams (rx/tx) plus the fx register bus, bundled for the master and its peers.
interface fx_bus_master_if
    import fx_bus_pkg::*;
#(
    parameter int AW = FX_AW,
    parameter int DW = FX_DW
);

    // Both byte streams: a byte moves on a rising clk_sys edge where vld && rdy;
    // the sender holds data and vld stable until that edge, rdy may change freely.
    logic [7:0]    rx_data;
    logic          rx_vld;
    logic          rx_rdy;
    logic [7:0]    tx_data;
    logic          tx_vld;
    logic          tx_rdy;
    logic [AW-1:0] fx_waddr;
    logic          fx_wr;
    logic [DW-1:0] fx_data;
    logic [AW-1:0] fx_raddr;
    logic          fx_rd;
    logic [DW-1:0] fx_q;

    modport master (
        input  rx_data, rx_vld, tx_rdy, fx_q,
        output rx_rdy, tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd
    );

    modport slave (
        output rx_data, rx_vld, tx_rdy, fx_q,
        input  rx_rdy, tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd
    );

endinterface

// File: rtl/fx_bus_master_rd_lat_pipe.sv
// Delays the fx_rd strobe by RD_LAT cycles so the master knows exactly when fx_q is valid.
module fx_rd_lat_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic rd,
    output logic cap_en
);

    logic [RD_LAT-1:0] sr;

    // The cast keeps the low RD_LAT bits, i.e. shifts rd in at bit 0 for any depth >= 1.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= RD_LAT'({sr, rd});
        end
    end

    assign cap_en = sr[RD_LAT-1];

endmodule

// File: rtl/fx_bus_master.sv
// Byte-stream command decoder driving fx_wr / fx_rd transactions and returning read data upstream.
module fx_bus_master
    import fx_bus_pkg::*;
#(
    parameter int AW     = FX_AW,
    parameter int DW     = FX_DW,
    parameter int RD_LAT = 2
) (
    input  logic             clk_sys,
    input  logic             rst,
    fx_bus_master_if.master  bus,
    output logic             busy,
    output logic [7:0]       err_cnt,
    output fx_state_e        state_dbg
);

    fx_state_e     state, state_n;
    logic          op_wr, op_wr_n;
    logic [AW-9:0] hi_q, hi_n;
    logic [AW-1:0] addr, addr_n;
    logic [8:0]    cnt, cnt_n;
    logic          wr_q, wr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic [AW-1:0] waddr_q, waddr_n;
    logic [AW-1:0] raddr_q, raddr_n;
    logic [7:0]    txd_q, txd_n;
    logic          txv_q, txv_n;
    logic [7:0]    err_q, err_n;
    logic          rx_rdy, rx_acc, tx_acc, cap_en;

    fx_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_rd_lat_pipe (
        .clk_sys (clk_sys),
        .rst     (rst),
        .rd      (bus.fx_rd),
        .cap_en  (cap_en)
    );

    assign rx_rdy = !(state inside {RISS, RWAIT, RSND});
    assign rx_acc = bus.rx_vld && rx_rdy;
    assign tx_acc = txv_q && bus.tx_rdy;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state   <= IDLE;
            op_wr   <= 1'b0;
            hi_q    <= '0;
            addr    <= '0;
            cnt     <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
            raddr_q <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state   <= state_n;
            op_wr   <= op_wr_n;
            hi_q    <= hi_n;
            addr    <= addr_n;
            cnt     <= cnt_n;
            wr_q    <= wr_n;
            wdata_q <= wdata_n;
            waddr_q <= waddr_n;
            raddr_q <= raddr_n;
            txd_q   <= txd_n;
            txv_q   <= txv_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        op_wr_n = op_wr;
        hi_n    = hi_q;
        addr_n  = addr;
        cnt_n   = cnt;
        wr_n    = 1'b0;
        wdata_n = wdata_q;
        waddr_n = waddr_q;
        raddr_n = raddr_q;
        txd_n   = txd_q;
        txv_n   = txv_q;
        err_n   = err_q;
        case (state)
            IDLE: if (rx_acc) begin
                if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
                    op_wr_n = (bus.rx_data == OP_WR);
                    state_n = ADR2;
                end else if (err_q != 8'hFF) begin
                    err_n = err_q + 8'd1;
                end
            end
            // Address bits above AW are simply never stored.
            ADR2: if (rx_acc) begin
                hi_n[AW-9:8] = bus.rx_data[AW-17:0];
                state_n      = ADR1;
            end
            ADR1: if (rx_acc) begin
                hi_n[7:0] = bus.rx_data;
                state_n   = ADR0;
            end
            ADR0: if (rx_acc) begin
                addr_n  = {hi_q, bus.rx_data};
                state_n = LEN;
            end
            LEN: if (rx_acc) begin
                cnt_n = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                if (op_wr) begin
                    state_n = WDAT;
                end else begin
                    raddr_n = addr;
                    state_n = RISS;
                end
            end
            WDAT: if (rx_acc) begin
                wr_n    = 1'b1;
                wdata_n = DW'(bus.rx_data);
                waddr_n = addr;
                addr_n  = addr + AW'(1);
                cnt_n   = cnt - 9'd1;
                if (cnt == 9'd1) state_n = IDLE;
            end
            RISS: state_n = RWAIT;
            RWAIT: if (cap_en) begin
                txd_n   = 8'(bus.fx_q);
                txv_n   = 1'b1;
                state_n = RSND;
            end
            RSND: if (tx_acc) begin
                txv_n  = 1'b0;
                addr_n = addr + AW'(1);
                cnt_n  = cnt - 9'd1;
                if (cnt == 9'd1) begin
                    state_n = IDLE;
                end else begin
                    raddr_n = addr + AW'(1);
                    state_n = RISS;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rx_rdy   = rx_rdy;
    assign bus.tx_data  = txd_q;
    assign bus.tx_vld   = txv_q;
    assign bus.fx_wr    = wr_q;
    assign bus.fx_data  = wdata_q;
    assign bus.fx_waddr = waddr_q;
    assign bus.fx_rd    = (state == RISS);
    assign bus.fx_raddr = raddr_q;
    assign busy         = (state != IDLE);
    assign err_cnt      = err_q;
    assign state_dbg    = state;

endmodule

// File: doc/fx_bus_master.md
Name: fx_bus_master

Overview:
- Initiator end of the fx register bus.
- Accepts a byte-stream command protocol from the host-side USB FIFO interface and turns it into fx_wr / fx_rd transactions against the configuration register bank.
- Read data returned on fx_q is packed back into the upstream byte stream.
- Sits between the USB FIFO front-end and control_top.

Parameters:
AW, 22, fx address width
DW, 8, fx data width
RD_LAT, 2, cycles from the fx_rd pulse to valid fx_q (1..4)

Ports:
clk_sys  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_data  in  8  command byte from host FIFO
rx_vld  in  1  rx_data valid
rx_rdy  out  1  master accepts rx_data this cycle
tx_data  out  8  read-back byte to host FIFO
tx_vld  out  1  tx_data valid
tx_rdy  in  1  host FIFO accepts tx_data
fx_waddr  out  AW  write address
fx_wr  out  1  write strobe, 1 cycle per byte
fx_data  out  DW  write data
fx_raddr  out  AW  read address
fx_rd  out  1  read strobe, 1 cycle per byte
fx_q  in  DW  read data, valid RD_LAT cycles after fx_rd
busy  out  1  high whenever state != IDLE
err_cnt  out  8  count of rejected opcodes, saturating

Behaviour:
- Clock and reset: one clock, clk_sys. rst is synchronous and active-high.
- Reset values: state IDLE; rx_rdy=1 (IDLE accepts); tx_vld=0; fx_wr=0; fx_rd=0; fx_waddr=0; fx_raddr=0; fx_data=0; tx_data=0; busy=0; err_cnt=0.
- Byte acceptance: a byte transfers when rx_vld && rx_rdy. tx transfers when tx_vld && tx_rdy.
- Frame format: OP, A2, A1, A0, LEN, then LEN data bytes if OP=write.
  - OP 0x01 = write, 0x02 = read.
  - Address is {A2,A1,A0}[AW-1:0]; extra high bits are ignored.
  - LEN 0 means 256.
- FSM states and transitions:
  - IDLE: on accepted byte:
    - 0x01 or 0x02 -> latch op, go ADR2.
    - Any other value -> err_cnt += 1 (saturate at 255), stay IDLE.
  - ADR2 / ADR1 / ADR0: latch one address byte each on accept; ADR0 -> LEN.
  - LEN: latch count (0 -> 256, 9-bit counter). Write -> WDAT; read -> RISS.
  - WDAT:
    - rx_rdy=1. On an accepted byte, the next cycle shows fx_wr=1, fx_data=byte, fx_waddr=current address.
    - Address increments by 1 after each write, wrapping 2^AW-1 -> 0. Count decrements.
    - When count reaches 0 -> IDLE.
    - Back-to-back accepted bytes produce back-to-back fx_wr pulses.
  - RISS: fx_rd=1 for exactly one cycle with fx_raddr=current address -> RWAIT.
  - RWAIT: wait RD_LAT cycles, capture fx_q into tx_data, set tx_vld=1 -> RSND.
  - RSND:
    - Hold tx_data and tx_vld until tx_rdy.
    - On transfer: tx_vld=0, address +1 (wrap), count -1.
    - If count == 0 -> IDLE, else -> RISS.
    - One read is outstanding at a time; per-byte read throughput is RD_LAT+2 cycles minimum.
- rx_rdy is 0 in RISS, RWAIT and RSND, and 1 in IDLE, ADR*, LEN and WDAT.
- fx_wr and fx_rd are never asserted in the same cycle. Each is a 1-cycle pulse and is 0 otherwise.
- fx_waddr and fx_raddr hold their last values between strobes.
- Reset mid-frame: all state is abandoned; the outputs return to their reset values the cycle after rst is sampled high. A pending tx byte is dropped. No partial write completes after reset.
- No timeout. A stalled host leaves the FSM waiting indefinitely, with busy=1.

Decomposition:
- Shared package fx_bus_pkg holds:
  - opcode constants OP_WR=8'h01, OP_RD=8'h02;
  - the state enum (IDLE, ADR2, ADR1, ADR0, LEN, WDAT, RISS, RWAIT, RSND);
  - FX_AW=22 and FX_DW=8.
- One natural sub-module, fx_rd_lat_pipe: an RD_LAT-deep shift of the fx_rd strobe that produces the capture enable for fx_q. Everything else stays in a single FSM.

Test Plan:
- Single write: 01 00 00 10 01 AB -> exactly one fx_wr pulse with fx_waddr=0x000010, fx_data=0xAB; busy low 1 cycle after the pulse.
- Burst write with wrap: 01 3F FF FE 03 11 22 33 -> fx_wr at 0x3FFFFE=0x11, 0x3FFFFF=0x22, 0x000000=0x33; with rx_vld held continuously, the three pulses are on consecutive cycles.
- Read, LEN 2, RD_LAT=2, responder model q=addr[7:0]^0x5A: 02 00 01 00 02 -> fx_rd at 0x000100 then 0x000101; tx bytes 0x5A, 0x5B. With tx_rdy stalled 5 cycles, tx_data and tx_vld are held stable and the second fx_rd is withheld until the first byte transfers.
- Bad opcode: 07 then 01 00 00 00 01 FF -> err_cnt=1 and no strobe for 07; the following write completes normally at 0x000000. Sending 300 bad bytes leaves err_cnt saturated at 255.
- LEN 0: 02 00 00 00 00 -> exactly 256 fx_rd pulses (0x000000..0x0000FF) and 256 tx bytes, then IDLE.
- Reset mid-write: assert rst after 2 of 4 data bytes -> no further fx_wr; all outputs at reset values the next cycle; a fresh frame afterwards executes correctly.
